// File: rtl/seq_booth_multiplier.sv
// Iterative radix-2 Booth multiplier: one 2*WIDTH-bit product per start, in WIDTH+2 cycles.
// Operands are extended to WIDTH+1 bits so one signed engine covers both signed and unsigned modes.
module seq_booth_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 tc,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t             r_state;
  logic [WIDTH:0]     r_a;
  logic [WIDTH:0]     r_q;
  logic               r_q1;
  logic [WIDTH:0]     r_m;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic               r_done;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_a_sh;
  logic [WIDTH:0]     w_q_sh;
  logic [WIDTH:0]     w_a_ext;
  logic [WIDTH:0]     w_b_ext;
  logic [2*WIDTH-1:0] w_prod;

  assign w_a_ext = {tc & a[WIDTH-1], a};
  assign w_b_ext = {tc & b[WIDTH-1], b};

  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_q1})
      2'b10:   w_sum = r_a - r_m;
      2'b01:   w_sum = r_a + r_m;
      default: w_sum = r_a;
    endcase
  end

  // Arithmetic right shift of {A,Q,q_1}; the two top product bits are pure sign and are dropped.
  assign w_a_sh = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign w_q_sh = {w_sum[0], r_q[WIDTH:1]};
  assign w_prod = {w_a_sh[WIDTH-2:0], w_q_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= w_a_ext;
            r_q     <= w_b_ext;
            r_a     <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= w_a_sh;
          r_q   <= w_q_sh;
          r_q1  <= r_q[0];
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH)) begin
            r_p     <= w_prod;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign p         = r_p;
  assign dbg_state = r_state;

endmodule
